// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle ops finish in one cycle; shifts move one bit per cycle.
// Results are presented with a valid/ready handshake and held until consumed.
module alu_seq_exec #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [N-1:0]  sh_val;
    logic [SW-1:0] cnt;
    logic          sh_left;

    logic [N-1:0]  calc;
    logic          calc_err;
    logic          is_shift;
    logic [SW-1:0] amt;
    logic [N-1:0]  sh_next;

    assign amt      = b[SW-1:0];
    assign is_shift = (alucontrol == 4'b0010) || (alucontrol == 4'b0011);
    assign sh_next  = sh_left ? (sh_val << 1) : (sh_val >> 1);

    // Shift codes resolve to a here; only used when the amount is zero.
    always_comb begin
        calc     = '0;
        calc_err = 1'b0;
        case (alucontrol)
            4'b0000: calc = a + b;
            4'b0001: calc = a - b;
            4'b0010: calc = a;
            4'b0011: calc = a;
            4'b0100: calc = a & b;
            4'b0101: calc = a | b;
            4'b0110: calc = a ^ b;
            4'b0111: calc = ~(a | b);
            4'b1000: calc = ~(a & b);
            4'b1001: calc = ~(a ^ b);
            4'b1010: calc = a;
            4'b1011: calc = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: calc = {{(N-1){1'b0}}, ($signed(a) > $signed(b))};
            default: calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            sh_val    <= '0;
            cnt       <= '0;
            sh_left   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_shift && (amt != '0)) begin
                            sh_val  <= a;
                            cnt     <= amt;
                            sh_left <= (alucontrol == 4'b0010);
                            state   <= SHIFT;
                        end else begin
                            result    <= calc;
                            zero      <= (calc == '0);
                            err       <= calc_err;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    sh_val <= sh_next;
                    cnt    <= cnt - 1'b1;
                    // Outputs stay frozen until the last shift lands.
                    if (cnt == SW'(1)) begin
                        result    <= sh_next;
                        zero      <= (sh_next == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
